sequencer_trigger_ctrl: RTL and testbench



---
 rtl/sequencer_trigger_pkg.sv | 20 ++
 rtl/trigger_pulse_filter.sv | 47 ++++
 rtl/sequencer_trigger_ctrl.sv | 122 ++++++++++++
 tb/tb_sequencer_trigger_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_trigger_pkg.sv
// Shared constants for the pixel-test sequencer trigger path: mode encodings,
// FSM state codes and default widths.
package sequencer_trigger_pkg;

   localparam int CNT_W_DEF     = 16;
   localparam int HOLDOFF_W_DEF = 10;
   localparam int FILT_W_DEF    = 4;

   localparam logic [1:0] MODE_EXT    = 2'b00;
   localparam logic [1:0] MODE_SW     = 2'b01;
   localparam logic [1:0] MODE_AUTO   = 2'b10;
   localparam logic [1:0] MODE_EXT_SW = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ARMED   = 2'd0;
   localparam state_t FIRE    = 2'd1;
   localparam state_t HOLDOFF = 2'd2;

endpackage

// File: rtl/trigger_pulse_filter.sv
// Two-flop synchroniser plus minimum-width filter for the external trigger;
// emits one event per qualifying pulse, however long the pulse lasts.
module trigger_pulse_filter #(
   parameter int FILT_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable_i,
   input  logic              async_i,
   input  logic [FILT_W-1:0] minWidth_i,
   output logic              evt_o
);

   logic              sync1_q;
   logic              sync2_q;
   logic [FILT_W-1:0] cnt_q;
   logic [FILT_W-1:0] cnt_d;
   logic [FILT_W-1:0] thresh;

   // Saturating high-time counter; the event fires only on the step that lands
   // on the threshold, so a held-high input cannot retrigger until it drops.
   always_comb begin
      thresh = minWidth_i;
      if (thresh == '0) thresh = FILT_W'(1);
      cnt_d = cnt_q;
      evt_o = 1'b0;
      if (!enable_i || !sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + FILT_W'(1);
         evt_o = (cnt_d == thresh);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/sequencer_trigger_ctrl.sv
// Merges external, software and auto triggers, gates them on ready_flag and a
// holdoff window, and issues single-cycle run_sequencer pulses with counters.
module sequencer_trigger_ctrl
   import sequencer_trigger_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int HOLDOFF_W = HOLDOFF_W_DEF,
   parameter int FILT_W    = FILT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ext_trigger,
   input  logic                 sw_trigger,
   input  logic                 enable,
   input  logic [1:0]           mode,
   input  logic [FILT_W-1:0]    min_width,
   input  logic [HOLDOFF_W-1:0] holdoff_time,
   input  logic [CNT_W-1:0]     auto_period,
   input  logic                 ready_flag,
   input  logic                 counters_clear,
   output logic                 run_sequencer,
   output logic                 busy,
   output logic [CNT_W-1:0]     trigger_count,
   output logic [CNT_W-1:0]     missed_count
);

   state_t               state_q, state_d;
   logic [HOLDOFF_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]     autoCnt_q, autoCnt_d;
   logic [CNT_W-1:0]     trigCnt_q, trigCnt_d;
   logic [CNT_W-1:0]     missCnt_q, missCnt_d;
   logic                 extEvt;
   logic                 autoEvt;
   logic                 anyEvt;
   logic                 trigInc;
   logic                 missInc;

   trigger_pulse_filter #(.FILT_W(FILT_W)) uFilter (
      .clk        (clk),
      .reset      (reset),
      .enable_i   (enable),
      .async_i    (ext_trigger),
      .minWidth_i (min_width),
      .evt_o      (extEvt)
   );

   // Auto counter is parked at zero whenever AUTO is not live, so each entry starts a fresh period.
   always_comb begin
      autoCnt_d = '0;
      autoEvt   = 1'b0;
      if (enable && mode == MODE_AUTO && auto_period != '0) begin
         if (autoCnt_q >= auto_period - CNT_W'(1)) autoEvt = 1'b1;
         else autoCnt_d = autoCnt_q + CNT_W'(1);
      end
      anyEvt = enable && ((extEvt && (mode == MODE_EXT || mode == MODE_EXT_SW)) ||
                          (sw_trigger && (mode == MODE_SW || mode == MODE_EXT_SW)) ||
                          autoEvt);
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      trigInc = 1'b0;
      missInc = 1'b0;
      case (state_q)
         ARMED: begin
            if (anyEvt && ready_flag) begin
               state_d = FIRE;
               trigInc = 1'b1;
            end else if (anyEvt) begin
               missInc = 1'b1;
            end
         end
         FIRE: begin
            missInc = anyEvt;
            hold_d  = holdoff_time;
            state_d = (holdoff_time != '0) ? HOLDOFF : ARMED;
         end
         HOLDOFF: begin
            missInc = anyEvt;
            hold_d  = hold_q - HOLDOFF_W'(1);
            if (hold_q <= HOLDOFF_W'(1)) state_d = ARMED;
         end
         default: state_d = ARMED;
      endcase
   end

   // A clear beats a same-cycle increment; that increment is simply dropped.
   always_comb begin
      trigCnt_d = trigCnt_q;
      missCnt_d = missCnt_q;
      if (counters_clear) begin
         trigCnt_d = '0;
         missCnt_d = '0;
      end else begin
         if (trigInc && trigCnt_q != '1) trigCnt_d = trigCnt_q + CNT_W'(1);
         if (missInc && missCnt_q != '1) missCnt_d = missCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARMED;
         hold_q    <= '0;
         autoCnt_q <= '0;
         trigCnt_q <= '0;
         missCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         autoCnt_q <= autoCnt_d;
         trigCnt_q <= trigCnt_d;
         missCnt_q <= missCnt_d;
      end
   end

   assign run_sequencer = (state_q == FIRE);
   assign busy          = (state_q != ARMED);
   assign trigger_count = trigCnt_q;
   assign missed_count  = missCnt_q;

endmodule

// File: tb/tb_sequencer_trigger_ctrl.sv
// Directed bench for sequencer_trigger_ctrl: filter latency, holdoff, auto
// period, source merging, counter saturation/clear and synchronous reset.
module tb_sequencer_trigger_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        extTrigger;
   logic        swTrigger;
   logic        enable;
   logic [1:0]  mode;
   logic [3:0]  minWidth;
   logic [9:0]  holdoffTime;
   logic [15:0] autoPeriod;
   logic        readyFlag;
   logic        countersClear;
   logic        runSequencer;
   logic        busy;
   logic [15:0] triggerCount;
   logic [15:0] missedCount;

   int testsRun    = 0;
   int testsFailed = 0;

   sequencer_trigger_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .ext_trigger    (extTrigger),
      .sw_trigger     (swTrigger),
      .enable         (enable),
      .mode           (mode),
      .min_width      (minWidth),
      .holdoff_time   (holdoffTime),
      .auto_period    (autoPeriod),
      .ready_flag     (readyFlag),
      .counters_clear (countersClear),
      .run_sequencer  (runSequencer),
      .busy           (busy),
      .trigger_count  (triggerCount),
      .missed_count   (missedCount)
   );

   always #5 clk = ~clk;

   // Advance one cycle and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic rdy, input logic [9:0] hold,
                                input logic [3:0] mw, input logic [15:0] per);
      mode        = m;
      readyFlag   = rdy;
      holdoffTime = hold;
      minWidth    = mw;
      autoPeriod  = per;
   endtask

   task automatic clearCounters();
      countersClear = 1'b1;
      tick();
      countersClear = 1'b0;
   endtask

   // Drives an ext pulse of the given width starting in cycle 0 and watches a window.
   task automatic pulseExt(input int width, input int window, output int firstRun, output int runs);
      firstRun   = -1;
      runs       = 0;
      extTrigger = 1'b1;
      for (int i = 1; i <= window; i++) begin
         tick();
         if (i == width) extTrigger = 1'b0;
         if (runSequencer) begin
            runs++;
            if (firstRun < 0) firstRun = i;
         end
      end
   endtask

   initial begin
      int firstRun, runs, lastRun, gapErr;
      logic [15:0] runMask, busyMask;

      reset = 1'b1; extTrigger = 1'b0; swTrigger = 1'b0; enable = 1'b1; countersClear = 1'b0;
      applyStimulus(2'b00, 1'b1, 10'd0, 4'd3, 16'd0);
      tick(); tick();
      reset = 1'b0;
      checkOutput("reset_run", 32'(runSequencer), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_trig", 32'(triggerCount), 32'd0);
      checkOutput("reset_miss", 32'(missedCount), 32'd0);

      // EXT filter: short pulse rejected, long pulse gives one run 5 cycles after the edge
      pulseExt(2, 12, firstRun, runs);
      checkOutput("ext_short_runs", 32'(runs), 32'd0);
      pulseExt(5, 12, firstRun, runs);
      checkOutput("ext_long_runs", 32'(runs), 32'd1);
      checkOutput("ext_long_latency", 32'(firstRun), 32'd5);
      checkOutput("ext_long_trig", 32'(triggerCount), 32'd1);
      minWidth = 4'd1;
      pulseExt(2, 12, firstRun, runs);
      checkOutput("ext_mw1_latency", 32'(firstRun), 32'd3);
      minWidth = 4'd0;
      pulseExt(2, 12, firstRun, runs);
      checkOutput("ext_mw0_latency", 32'(firstRun), 32'd3);
      checkOutput("ext_mw0_trig", 32'(triggerCount), 32'd3);

      // SW with holdoff 4: triggers at 0, 2, 7
      clearCounters();
      applyStimulus(2'b01, 1'b1, 10'd4, 4'd1, 16'd0);
      runMask = '0; busyMask = '0;
      swTrigger = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         swTrigger = (i == 2 || i == 7);
         if (runSequencer) runMask[i] = 1'b1;
         if (busy) busyMask[i] = 1'b1;
      end
      checkOutput("sw_run_cycles", 32'(runMask), 32'h0102);
      checkOutput("sw_busy_cycles", 32'(busyMask), 32'h1F3E);
      checkOutput("sw_missed", 32'(missedCount), 32'd1);
      checkOutput("sw_trig", 32'(triggerCount), 32'd2);
      tick(); tick(); tick();

      // AUTO period 10 over 100 cycles
      holdoffTime = 10'd0;
      clearCounters();
      applyStimulus(2'b10, 1'b1, 10'd0, 4'd1, 16'd10);
      runs = 0; firstRun = -1; lastRun = -1; gapErr = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (runSequencer) begin
            runs++;
            if (firstRun < 0) firstRun = i;
            if (lastRun >= 0 && i - lastRun != 10) gapErr++;
            lastRun = i;
         end
      end
      checkOutput("auto_runs", 32'(runs), 32'd10);
      checkOutput("auto_first", 32'(firstRun), 32'd10);
      checkOutput("auto_gaps", 32'(gapErr), 32'd0);
      checkOutput("auto_trig", 32'(triggerCount), 32'd10);
      autoPeriod = 16'd0;
      runs = 0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (runSequencer) runs++;
      end
      checkOutput("auto_zero_runs", 32'(runs), 32'd0);

      // EXT_SW not ready: coincident ext and sw events count once
      clearCounters();
      applyStimulus(2'b11, 1'b0, 10'd0, 4'd1, 16'd0);
      extTrigger = 1'b1;
      tick();
      tick();
      swTrigger = 1'b1;
      tick();
      swTrigger = 1'b0; extTrigger = 1'b0;
      runs = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (runSequencer) runs++;
      end
      checkOutput("extsw_runs", 32'(runs), 32'd0);
      checkOutput("extsw_missed", 32'(missedCount), 32'd1);
      readyFlag = 1'b1;
      swTrigger = 1'b1;
      tick();
      swTrigger = 1'b0;
      checkOutput("extsw_ready_run", 32'(runSequencer), 32'd1);
      tick();
      checkOutput("extsw_ready_trig", 32'(triggerCount), 32'd1);

      // Missed counter saturation, then clear racing an accepted trigger
      applyStimulus(2'b01, 1'b0, 10'd0, 4'd1, 16'd0);
      swTrigger = 1'b1;
      for (int i = 0; i < 65540; i++) tick();
      swTrigger = 1'b0;
      tick();
      checkOutput("miss_saturate", 32'(missedCount), 32'hFFFF);
      readyFlag = 1'b1;
      swTrigger = 1'b1;
      tick();
      swTrigger = 1'b0;
      tick();
      checkOutput("trig_before_clear", 32'(triggerCount), 32'd2);
      swTrigger = 1'b1; countersClear = 1'b1;
      tick();
      swTrigger = 1'b0; countersClear = 1'b0;
      checkOutput("clear_race_run", 32'(runSequencer), 32'd1);
      checkOutput("clear_race_trig", 32'(triggerCount), 32'd0);
      checkOutput("clear_race_miss", 32'(missedCount), 32'd0);
      tick();

      // Reset during a long holdoff, then immediate re-trigger
      applyStimulus(2'b01, 1'b1, 10'd500, 4'd1, 16'd0);
      swTrigger = 1'b1;
      tick();
      swTrigger = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("holdoff_busy", 32'(busy), 32'd1);
      checkOutput("holdoff_trig", 32'(triggerCount), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst_hold_busy", 32'(busy), 32'd0);
      checkOutput("rst_hold_run", 32'(runSequencer), 32'd0);
      checkOutput("rst_hold_trig", 32'(triggerCount), 32'd0);
      checkOutput("rst_hold_miss", 32'(missedCount), 32'd0);
      tick();
      swTrigger = 1'b1;
      tick();
      swTrigger = 1'b0;
      checkOutput("post_rst_run", 32'(runSequencer), 32'd1);
      checkOutput("post_rst_trig", 32'(triggerCount), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
